skew_fifo_bank: RTL and testbench
=================================

# skew_fifo_bank

Parametrised multi-lane input buffer: `lanes` independent synchronous FIFOs of `bw`-bit words, written as one vector and read either all lanes at once or with a per-lane diagonal skew. It is the next-generation replacement for the fixed-depth L0 / IFIFO buffers in the corelet. It feeds the west (L0) and north (IFIFO) edges of the MAC array, and produces the skewed wavefront the array needs without external delay logic.

## Interface
Parameters:
- `bw`, 4: word width per lane.
- `lanes`, 8: number of lanes. Use `row` for the L0 role and `col` for the IFIFO role.
- `depth`, 64: entries per lane. Must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wr` in 1: push one word into every lane from `in`.
- `rd` in 1: read request.
- `mode` in 1: 0 = broadcast read, 1 = skewed read.
- `in` in `lanes*bw`: write vector; lane 0 in the LSBs.
- `out` out `lanes*bw`: registered read data; lane 0 in the LSBs.
- `o_valid` out `lanes`: bit i high for one cycle when lane i's `out` slice was updated.
- `o_full` out 1: at least one lane holds `depth` entries.
- `o_ready` out 1: equals `~o_full`; a write is accepted.
- `o_empty` out 1: all lanes empty and the skew pipeline is idle.
- `o_overflow` out 1: sticky; set by a dropped write.
- `o_underflow` out 1: sticky; set by a lane pop on an empty lane.

## Operation
- **Write.** A write is accepted iff `wr` and `o_ready` are both high in that cycle. All lanes push together. Otherwise the write is dropped with no state change, and `o_overflow` is set if `wr` was high. A simultaneous pop that frees a slot does not rescue a write attempted while `o_full` is high.
- **Effective lane read `rd_i`.**
  - Broadcast mode: `rd_i = rd` for every lane.
  - Skewed mode: `rd_i` = `rd` delayed by i cycles, through a `lanes-1` stage shift register. Lane 0 is undelayed.
- **Pop.** On `rd_i` with lane i non-empty: pop, load the word into `out[i]`, and pulse `o_valid[i]`.
  - On `rd_i` with lane i empty: no pop, `out[i]` holds, `o_valid[i]` stays low, `o_underflow` is set.
- **Mode latching.** `mode` is latched into an internal `mode_q` only while the skew shift register is all-zero. A change while skewed reads are in flight takes effect once they drain. Reads during the drain use the old mode.
- **Simultaneous push and pop on a lane.** Both take effect, the lane count is unchanged, and FIFO order is preserved.
- **Pointers.** Each lane has read/write pointers of `log2(depth)` bits that wrap modulo `depth`. The count is `log2(depth)+1` bits, so full and empty are unambiguous.
- **Flags.** `o_overflow` and `o_underflow` clear only on `reset`.

## Timing
- **Reset values.**
  - `out`, `o_valid`, `o_full`, `o_overflow`, `o_underflow`, all pointers and counts, the skew register and `mode_q` are 0.
  - `o_ready` and `o_empty` are 1.
- **Reset mid-operation.** Reset cancels pending skewed reads; no `o_valid` follows release.
- **Write to read.** A word written at edge N can be popped by `rd` sampled at edge N+1.
- **Read latency.** `rd` sampled at edge N gives:
  - broadcast: all lanes' `out` and `o_valid` visible after edge N;
  - skewed: lane i visible after edge N+i.
- **Back-to-back.** `rd` every cycle streams one word per lane per cycle in either mode. In skewed mode the lane-i stream trails lane 0 by i cycles.
- **Status outputs.** `o_full`, `o_ready` and `o_empty` are derived combinationally from the registered counts; there is no lookahead.
- **Skewed-mode counts.** Lane counts may differ by up to `lanes-1`. `o_full` reflects the fullest lane.

## Structure
- A shared package holds `MODE_BCAST = 1'b0`, `MODE_SKEW = 1'b1`, and a `clog2`-based pointer/count width function.
- Sub-module `lane_fifo`: a single-lane synchronous FIFO with parameters `bw` and `depth` and ports `clk`, `reset`, `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`. It is instantiated `lanes` times.
- The top level contains the skew shift register, the mode latch, the flag logic, and the status reductions.

## Test plan
All scenarios use `lanes=4`, `bw=4`, `depth=4`.
1. **Broadcast read.** Reset, write `in=0x3210`, `rd` next cycle in mode 0 → `out=0x3210` and `o_valid=4'b1111` for exactly one cycle; `o_empty` returns to 1.
2. **Overflow.** Write `0x0000`, `0x1111`, `0x2222`, `0x3333` → `o_full=1`, `o_ready=0`. A fifth write `0xFFFF` is dropped and sets `o_overflow=1`. Four reads return `0x0000` through `0x3333` in order.
3. **Skewed read.** Mode 1, write `0x4321`, single `rd` pulse at edge N → `o_valid` is `0001` after N, `0010` after N+1, `0100` after N+2, `1000` after N+3; final `out=0x4321`.
4. **Underflow.** `rd` on an empty bank → `o_valid=0`, `out` unchanged, `o_underflow=1`, and it stays 1 after later valid reads.
5. **Push plus pop.** With 2 entries, drive `wr` and `rd` together (mode 0) → count stays 2 and the output order matches the write order. Then toggle `mode` while a skewed read is in flight → the old mode completes before the new one applies.
6. **Reset mid-skew.** Assert `reset` one cycle after a skewed `rd` (lane 0 done, lanes 1–3 pending) → all outputs go to their reset values asynchronously, with no `o_valid` pulses after release.

Source files
------------

// File: rtl/skew_fifo_bank_pkg.sv
// Shared types and helpers for the skewed multi-lane FIFO bank.
// Read-mode encodings and pointer width helper.
package skew_fifo_bank_pkg;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_SKEW  = 1'b1;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/skew_fifo_bank_lane.sv
// Single-lane synchronous FIFO with wrap-around pointers.
// Count is one bit wider than the pointers so full/empty are distinct.
module lane_fifo
  import skew_fifo_bank_pkg::*;
#(
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [bw-1:0]           din,
  output logic [bw-1:0]           dout,
  output logic [ptr_w(depth):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = ptr_w(depth);
  localparam int CW = AW + 1;

  logic [bw-1:0] mem [depth];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign dout  = mem[rp];
  assign full  = (count == CW'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/skew_fifo_bank.sv
// Multi-lane input buffer with broadcast or diagonally skewed reads.
// Feeds the MAC array edges with the wavefront it expects.
module skew_fifo_bank
  import skew_fifo_bank_pkg::*;
#(
  parameter int bw    = 4,
  parameter int lanes = 8,
  parameter int depth = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  mode,
  input  logic [lanes*bw-1:0]   in,
  output logic [lanes*bw-1:0]   out,
  output logic [lanes-1:0]      o_valid,
  output logic                  o_full,
  output logic                  o_ready,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int CW = ptr_w(depth) + 1;

  logic [bw-1:0]    dout [lanes];
  logic [CW-1:0]    cnt  [lanes];
  logic [lanes-1:0] full;
  logic [lanes-1:0] empty;
  logic [lanes-1:0] cnt_z;
  logic [lanes-1:0] rd_i;
  logic [lanes-1:0] pop;
  logic [lanes-2:0] sk;
  logic             mode_q;
  logic             wr_ok;
  logic             sk_load;

  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign wr_ok   = wr & o_ready;
  assign sk_load = rd & (mode_q == MODE_SKEW);
  assign o_empty = (&cnt_z) & ~(|sk);

  // Per-lane effective read and pop qualification.
  always_comb begin
    rd_i  = '0;
    cnt_z = '0;
    rd_i[0] = rd;
    for (int i = 1; i < lanes; i++)
      rd_i[i] = (mode_q == MODE_SKEW) ? sk[i-1] : rd;
    for (int i = 0; i < lanes; i++)
      cnt_z[i] = (cnt[i] == '0);
    pop = rd_i & ~empty;
  end

  for (genvar g = 0; g < lanes; g++) begin : g_lane
    lane_fifo #(.bw(bw), .depth(depth)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_ok),
      .pop   (pop[g]),
      .din   (in[g*bw +: bw]),
      .dout  (dout[g]),
      .count (cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Skew delay line; mode only changes once nothing is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sk     <= '0;
      mode_q <= MODE_BCAST;
    end else begin
      sk[0] <= sk_load;
      for (int i = 1; i < lanes - 1; i++)
        sk[i] <= sk[i-1];
      if (!(|sk) && !sk_load)
        mode_q <= mode;
    end
  end

  // Registered read data and per-lane valid strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out     <= '0;
      o_valid <= '0;
    end else begin
      o_valid <= pop;
      for (int i = 0; i < lanes; i++)
        if (pop[i]) out[i*bw +: bw] <= dout[i];
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr && !o_ready)    o_overflow  <= 1'b1;
      if (|(rd_i & empty))   o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Directed self-checking bench for skew_fifo_bank.
// Four lanes, 4-bit words, depth 4.
module tb_skew_fifo_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        rd;
  logic        mode;
  logic [15:0] in;
  logic [15:0] out;
  logic [3:0]  o_valid;
  logic        o_full;
  logic        o_ready;
  logic        o_empty;
  logic        o_overflow;
  logic        o_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  skew_fifo_bank #(.bw(4), .lanes(4), .depth(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .mode        (mode),
    .in          (in),
    .out         (out),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] eo,
                        input logic [3:0] ev);
    chk({tag, "_out"}, {16'h0, out}, {16'h0, eo});
    chk({tag, "_vld"}, {28'h0, o_valid}, {28'h0, ev});
  endtask

  initial begin
    reset = 1'b1;
    wr = 1'b0; rd = 1'b0; mode = 1'b0; in = 16'h0;
    step(); step();
    chk("rst_out", {16'h0, out}, 32'h0);
    chk("rst_vld", {28'h0, o_valid}, 32'h0);
    chk("rst_full", {31'h0, o_full}, 32'h0);
    chk("rst_ready", {31'h0, o_ready}, 32'h1);
    chk("rst_empty", {31'h0, o_empty}, 32'h1);
    chk("rst_ovf", {31'h0, o_overflow}, 32'h0);
    chk("rst_unf", {31'h0, o_underflow}, 32'h0);
    reset = 1'b0;
    step();

    // broadcast read
    wr = 1'b1; in = 16'h3210; step();
    chk("t1_empty0", {31'h0, o_empty}, 32'h0);
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t1_rd", 16'h3210, 4'hF);
    chk("t1_empty1", {31'h0, o_empty}, 32'h1);
    rd = 1'b0; step();
    chk_rd("t1_idle", 16'h3210, 4'h0);

    // fill to full, then overflow
    wr = 1'b1;
    in = 16'h0000; step();
    in = 16'h1111; step();
    in = 16'h2222; step();
    chk("t2_nfull", {31'h0, o_full}, 32'h0);
    in = 16'h3333; step();
    chk("t2_full", {31'h0, o_full}, 32'h1);
    chk("t2_ready", {31'h0, o_ready}, 32'h0);
    chk("t2_ovf0", {31'h0, o_overflow}, 32'h0);
    in = 16'hFFFF; step();
    chk("t2_ovf1", {31'h0, o_overflow}, 32'h1);
    chk("t2_full2", {31'h0, o_full}, 32'h1);
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t2_r0", 16'h0000, 4'hF);
    chk("t2_ready2", {31'h0, o_ready}, 32'h1);
    step(); chk_rd("t2_r1", 16'h1111, 4'hF);
    step(); chk_rd("t2_r2", 16'h2222, 4'hF);
    step(); chk_rd("t2_r3", 16'h3333, 4'hF);
    rd = 1'b0; step();
    chk("t2_empty", {31'h0, o_empty}, 32'h1);
    chk("t2_unf", {31'h0, o_underflow}, 32'h0);

    // skewed read
    mode = 1'b1; step();
    wr = 1'b1; in = 16'h4321; step();
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t3_n0", 16'h3331, 4'b0001);
    chk("t3_busy", {31'h0, o_empty}, 32'h0);
    rd = 1'b0; step();
    chk_rd("t3_n1", 16'h3321, 4'b0010);
    step(); chk_rd("t3_n2", 16'h3321, 4'b0100);
    step(); chk_rd("t3_n3", 16'h4321, 4'b1000);
    chk("t3_empty", {31'h0, o_empty}, 32'h1);
    step(); chk_rd("t3_n4", 16'h4321, 4'b0000);

    // underflow
    mode = 1'b0; step();
    rd = 1'b1; step();
    chk_rd("t4_rd", 16'h4321, 4'h0);
    chk("t4_unf", {31'h0, o_underflow}, 32'h1);
    rd = 1'b0; wr = 1'b1; in = 16'h5555; step();
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t4_ok", 16'h5555, 4'hF);
    chk("t4_unf2", {31'h0, o_underflow}, 32'h1);
    rd = 1'b0; step();

    // push plus pop with two entries held
    wr = 1'b1;
    in = 16'h1234; step();
    in = 16'h5678; step();
    rd = 1'b1; in = 16'h9ABC; step();
    chk_rd("t5_pp", 16'h1234, 4'hF);
    rd = 1'b0; in = 16'hDEF0; step();
    chk("t5_nfull", {31'h0, o_full}, 32'h0);
    in = 16'h1357; step();
    chk("t5_full", {31'h0, o_full}, 32'h1);
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t5_r0", 16'h5678, 4'hF);
    step(); chk_rd("t5_r1", 16'h9ABC, 4'hF);
    step(); chk_rd("t5_r2", 16'hDEF0, 4'hF);
    step(); chk_rd("t5_r3", 16'h1357, 4'hF);
    rd = 1'b0; step();
    chk("t5_empty", {31'h0, o_empty}, 32'h1);

    // mode change while skewed read drains
    mode = 1'b1; step();
    wr = 1'b1; in = 16'h2468; step();
    wr = 1'b0; rd = 1'b1; mode = 1'b0; step();
    chk_rd("t5_m0", 16'h1358, 4'b0001);
    rd = 1'b0; step();
    chk_rd("t5_m1", 16'h1368, 4'b0010);
    step(); chk_rd("t5_m2", 16'h1468, 4'b0100);
    step(); chk_rd("t5_m3", 16'h2468, 4'b1000);
    wr = 1'b1; in = 16'h1111; step();
    chk_rd("t5_m4", 16'h2468, 4'b0000);
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t5_bc", 16'h1111, 4'hF);
    rd = 1'b0; step();

    // reset while skewed read is in flight
    mode = 1'b1; step();
    wr = 1'b1; in = 16'h7777; step();
    wr = 1'b0; rd = 1'b1; step();
    chk_rd("t6_n0", 16'h1117, 4'b0001);
    rd = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_rd("t6_async", 16'h0000, 4'h0);
    chk("t6_full", {31'h0, o_full}, 32'h0);
    chk("t6_ready", {31'h0, o_ready}, 32'h1);
    chk("t6_empty", {31'h0, o_empty}, 32'h1);
    chk("t6_ovf", {31'h0, o_overflow}, 32'h0);
    chk("t6_unf", {31'h0, o_underflow}, 32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_rd("t6_post", 16'h0000, 4'h0);
    end
    chk("t6_empty2", {31'h0, o_empty}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
